mux_n_1_pipe: RTL and testbench
===============================

# mux_n_1_pipe

Parametrised N-way, WIDTH-bit selector with a registered, valid/ready-handshaked output stage. It generalises the fixed 32-bit 3:1 datapath select (ALU result / memory load / PC+4 writeback, and operand forwarding) so the pipelined core can insert select points between stages without breaking the backpressure chain. An illegal select outputs zero. Illegal selects are also recorded in a sticky error flag and a saturating counter for debug.

## Interface
- WIDTH, 32: data width of every input and the output.
- N, 3: number of inputs, 2..16.
- SEL_W, $clog2(N): select width, derived, not overridden.

- clk_i  in  1  rising-edge clock; the only clock.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  N*WIDTH  input k occupies bits [k*WIDTH +: WIDTH].
- sel_i  in  SEL_W  input index, sampled with valid_i.
- valid_i  in  1  upstream beat present.
- ready_o  out  1  block can accept a beat this cycle.
- data_out_o  out  WIDTH  registered selected data.
- valid_o  out  1  data_out_o holds a beat.
- ready_i  in  1  downstream accepts data_out_o.
- clr_err_i  in  1  synchronous clear of err_o and err_cnt_o.
- err_o  out  1  sticky: an accepted beat had sel_i >= N.
- err_cnt_o  out  8  count of accepted illegal beats, saturates at 255.

## Operation
- The input handshake completes when valid_i && ready_o. The output handshake completes when valid_o && ready_i.
- Selected value = data_i[sel_i*WIDTH +: WIDTH] if sel_i < N, else all zeros.
- An illegal select still produces a normal beat of zeros, with the same handshake.
- Output stage: one register (out_data, out_valid). When MUX_N_1_SKID_EN is set, a second skid register (skid_data, skid_valid) is added.
- Each accepted illegal beat sets err_o and increments err_cnt_o, holding at 255.
- clr_err_i forces err_o to 0 and err_cnt_o to 0. If an illegal beat is accepted in the same cycle as clr_err_i, the result is err_o=1 and err_cnt_o=1 (the new event wins).
- Data never reorders and is never dropped or duplicated.
- Selection is evaluated at the input handshake. Later changes to data_i or sel_i do not affect beats already held.

## Timing
- Reset values: data_out_o=0, valid_o=0, err_o=0, err_cnt_o=0. ready_o=1 once rst_ni is low (skid empty or output empty).
- Reset asserted mid-operation discards all held beats immediately. No partial beat appears after reset is released.
- Latency: an input accepted in cycle t is visible on data_out_o/valid_o in cycle t+1, when the output register is free.
- Output register update rules, evaluated per cycle in order:
  - Skid full and output handshake: out <= skid, skid emptied.
  - Else input handshake and (!out_valid || ready_i): out <= new beat.
  - Else input handshake: skid <= new beat. This case exists in skid builds only.
  - Else output handshake: out_valid <= 0.
- An input and output handshake in the same cycle sustains 1 beat per cycle.
- valid_o and data_out_o are stable while valid_o && !ready_i.

## Configuration
- MUX_N_1_SKID_EN defined:
  - Skid register present.
  - ready_o = !skid_valid, driven purely from a register, so there is no combinational ready_i -> ready_o path.
  - Up to 2 beats are buffered.
  - Full throughput under any ready_i pattern.
- MUX_N_1_SKID_EN undefined:
  - No skid register.
  - ready_o = !out_valid || ready_i, which is combinational from ready_i.
  - 1 beat is buffered.
  - Full throughput while ready_i=1.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then N=3, WIDTH=32, ready_i=1, inputs {0x11111111, 0x22222222, 0x33333333}. Drive sel_i = 0, 1, 2 on consecutive cycles with valid_i=1. Required: data_out_o = 0x11111111, 0x22222222, 0x33333333 in cycles t+1..t+3, valid_o held at 1.
- sel_i=3 with valid_i=1 at N=3. Required: a zero beat on data_out_o, err_o=1, err_cnt_o=1. Repeat 300 times: err_cnt_o holds at 255. Pulse clr_err_i: both fields read 0 next cycle.
- Same cycle: clr_err_i=1 and an illegal beat accepted. Required: err_o=1, err_cnt_o=1.
- Skid build: hold ready_i=0 and stream 3 beats A, B, C. Required: A in the output register, B in skid, ready_o=0 from the following cycle, C held upstream. Release ready_i. Required: A, B, C emerge in order on consecutive cycles.
- No-skid build, ready_i=0 with the output full. Required: ready_o=0 in the same cycle. Raise ready_i: ready_o rises in the same cycle and the next beat is accepted.
- Pull rst_ni low while 2 beats are held. Required: valid_o=0 and data_out_o=0 immediately, asynchronously. Release reset: no stale beats appear and ready_o=1.

Source files
------------

// File: rtl/mux_n_1_pipe.sv
// rtl/mux_n_1_pipe.sv - N-way WIDTH-bit select with registered valid/ready output stage
// Optional second (skid) output register enabled by MUX_N_1_SKID_EN.
module mux_n_1_pipe #(
   parameter  int WIDTH = 32,
   parameter  int N     = 3,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]   sel_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic [WIDTH-1:0]   data_out_o,
   output logic               valid_o,
   input  logic               ready_i,
   input  logic               clr_err_i,
   output logic               err_o,
   output logic [7:0]         err_cnt_o
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_legal;
   logic             in_hs;
   logic             out_hs;
   logic             illegal_acc;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   // Out-of-range selects match no input and fall through to zero.
   always_comb begin
      sel_data  = '0;
      sel_legal = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (sel_i == SEL_W'(k)) begin
            sel_data  = data_i[k*WIDTH +: WIDTH];
            sel_legal = 1'b1;
         end
      end
   end

   assign in_hs       = valid_i && ready_o;
   assign out_hs      = out_valid_q && ready_i;
   assign illegal_acc = in_hs && !sel_legal;

`ifdef MUX_N_1_SKID_EN
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_valid_q, skid_valid_d;

   // Ready is a pure register output, breaking the ready_i -> ready_o path.
   assign ready_o = !skid_valid_q;

   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (skid_valid_q && out_hs) begin
         out_data_d   = skid_data_q;
         skid_valid_d = 1'b0;
      end else if (in_hs && (!out_valid_q || ready_i)) begin
         out_data_d  = sel_data;
         out_valid_d = 1'b1;
      end else if (in_hs) begin
         skid_data_d  = sel_data;
         skid_valid_d = 1'b1;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign ready_o = !out_valid_q || ready_i;

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (in_hs) begin
         out_data_d  = sel_data;
         out_valid_d = 1'b1;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   // A new illegal event outranks a simultaneous clear.
   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (illegal_acc) begin
         err_d = 1'b1;
         if (clr_err_i) begin
            err_cnt_d = 8'd1;
         end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (clr_err_i) begin
         err_d     = 1'b0;
         err_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign data_out_o = out_data_q;
   assign valid_o    = out_valid_q;
   assign err_o      = err_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb/tb_mux_n_1_pipe.sv - randomized and directed bench for mux_n_1_pipe against a queue model
// Build with or without MUX_N_1_SKID_EN; the model's buffer depth follows the macro.
module tb_mux_n_1_pipe;
   localparam int WIDTH = 32;
   localparam int N     = 3;
   localparam int SEL_W = 2;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic [N*WIDTH-1:0] data_i = '0;
   logic [SEL_W-1:0]   sel_i = '0;
   logic               valid_i = 1'b0;
   logic               ready_o;
   logic [WIDTH-1:0]   data_out_o;
   logic               valid_o;
   logic               ready_i = 1'b0;
   logic               clr_err_i = 1'b0;
   logic               err_o;
   logic [7:0]         err_cnt_o;

   mux_n_1_pipe #(.WIDTH(WIDTH), .N(N)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .data_i     (data_i),
      .sel_i      (sel_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_out_o (data_out_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .clr_err_i  (clr_err_i),
      .err_o      (err_o),
      .err_cnt_o  (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Beats held by the block, oldest first, plus the debug counters.
   logic [WIDTH-1:0] exp_q[$];
   logic             exp_err = 1'b0;
   int               exp_cnt = 0;

`ifdef MUX_N_1_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] d, input int s);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) if (k == s) r = d[k*WIDTH +: WIDTH];
      return r;
   endfunction

   // Called just after a falling edge with inputs already applied; returns at the next falling edge.
   task automatic step(output bit acc);
      bit exp_ready;
      bit out_hs;
      int s;
      #1;
      if (DEPTH == 2) exp_ready = exp_q.size() < 2;
      else            exp_ready = (exp_q.size() == 0) || ready_i;
      check("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("data_out_o", 64'(data_out_o), 64'(exp_q[0]));
      check("ready_o", 64'(ready_o), 64'(exp_ready));
      check("err_o", 64'(err_o), 64'(exp_err));
      check("err_cnt_o", 64'(err_cnt_o), 64'(exp_cnt));
      acc    = valid_i && exp_ready;
      out_hs = (exp_q.size() > 0) && ready_i;
      s      = int'(sel_i);
      @(posedge clk_i);
      if (out_hs) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pick(data_i, s));
      if (acc && s >= N) begin
         exp_err = 1'b1;
         exp_cnt = clr_err_i ? 1 : (exp_cnt < 255 ? exp_cnt + 1 : 255);
      end else if (clr_err_i) begin
         exp_err = 1'b0;
         exp_cnt = 0;
      end
      @(negedge clk_i);
   endtask

   task automatic cyc(input bit v, input int s, input bit r, input bit c);
      bit acc;
      valid_i   = v;
      sel_i     = SEL_W'(s);
      ready_i   = r;
      clr_err_i = c;
      step(acc);
   endtask

   logic [WIDTH-1:0] burst[3];

   initial begin
      bit acc;
      int idx;

      // Reset values while reset is held.
      ready_i = 1'b1;
      #12;
      check("rst_valid_o", 64'(valid_o), 64'(0));
      check("rst_data_out_o", 64'(data_out_o), 64'(0));
      check("rst_err_o", 64'(err_o), 64'(0));
      check("rst_err_cnt_o", 64'(err_cnt_o), 64'(0));
      check("rst_ready_o", 64'(ready_o), 64'(1));
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Consecutive legal selects at full throughput.
      data_i = {32'h33333333, 32'h22222222, 32'h11111111};
      for (int s = 0; s < 3; s++) cyc(1'b1, s, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Illegal selects: zero beats, sticky flag, saturating count, then clear.
      for (int i = 0; i < 300; i++) cyc(1'b1, 3, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("cnt_saturated", 64'(err_cnt_o), 64'(255));
      cyc(1'b0, 0, 1'b1, 1'b1);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Clear and illegal beat in the same cycle: the event wins.
      cyc(1'b1, 1, 1'b1, 1'b0);
      cyc(1'b1, 3, 1'b1, 1'b1);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("clr_vs_event_err", 64'(err_o), 64'(1));
      check("clr_vs_event_cnt", 64'(err_cnt_o), 64'(1));
      cyc(1'b0, 0, 1'b1, 1'b1);

      // Backpressure: present A, B, C each held until accepted; ready_i released later.
      burst[0] = 32'hAAAA0001;
      burst[1] = 32'hBBBB0002;
      burst[2] = 32'hCCCC0003;
      idx = 0;
      for (int c = 0; c < 16 && idx < 3; c++) begin
         valid_i   = 1'b1;
         data_i    = {32'h0, 32'h0, burst[idx]};
         sel_i     = '0;
         ready_i   = (c >= 5);
         clr_err_i = 1'b0;
         step(acc);
         if (acc) idx++;
      end
      check("burst_accepted", 64'(idx), 64'(3));
      for (int c = 0; c < 4; c++) cyc(1'b0, 0, 1'b1, 1'b0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         data_i = {$urandom, $urandom, $urandom};
         cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 3),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset while beats are held.
      data_i = {32'h0, 32'h5A5A5A5A, 32'hA5A5A5A5};
      cyc(1'b1, 0, 1'b0, 1'b0);
      cyc(1'b1, 1, 1'b0, 1'b0);
      cyc(1'b1, 3, 1'b0, 1'b0);
      check("held_before_rst", 64'(valid_o), 64'(1));
      #3;
      rst_ni = 1'b0;
      #1;
      check("async_rst_valid_o", 64'(valid_o), 64'(0));
      check("async_rst_data_out_o", 64'(data_out_o), 64'(0));
      exp_q.delete();
      exp_err = 1'b0;
      exp_cnt = 0;
      valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) cyc(1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 2, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
